// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Requester, result and shared-ALU signals of alu_arbiter, directions seen
// from the arbiter (slave) and from the requesters/ALU side (master).
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if;
  logic       i_req0;
  logic       i_req1;
  logic [2:0] i_op0;
  logic [2:0] i_op1;
  logic [3:0] i_a0;
  logic [3:0] i_b0;
  logic [3:0] i_a1;
  logic [3:0] i_b1;
  logic       i_c0;
  logic       i_c1;
  logic       o_gnt0;
  logic       o_gnt1;
  logic       o_done0;
  logic       o_done1;
  logic [3:0] o_result;
  logic       o_carry;
  logic       o_busy;
  logic [2:0] o_alu_select;
  logic [3:0] o_alu_a;
  logic [3:0] o_alu_b;
  logic       o_alu_c;
  logic [3:0] i_alu_out;
  logic       i_alu_cout;

  modport slave (
    input  i_req0, i_req1, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1, i_c0, i_c1,
    input  i_alu_out, i_alu_cout,
    output o_gnt0, o_gnt1, o_done0, o_done1, o_result, o_carry, o_busy,
    output o_alu_select, o_alu_a, o_alu_b, o_alu_c
  );

  modport master (
    output i_req0, i_req1, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1, i_c0, i_c1,
    output i_alu_out, i_alu_cout,
    input  o_gnt0, o_gnt1, o_done0, o_done1, o_result, o_carry, o_busy,
    input  o_alu_select, o_alu_a, o_alu_b, o_alu_c
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Round-robin arbiter giving two requesters access to one shared registered
// ALU; one operation in flight at a time.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [2:0] c_LAT = 3'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic       r_owner;
  logic [2:0] r_cnt;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_done0;
  logic       r_done1;
  logic [3:0] r_result;
  logic       r_carry;
  logic [2:0] r_alu_sel;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic       r_alu_c;
  logic       w_any;
  logic       w_win;
  logic       w_last_cycle;

  always_comb begin
    w_any        = bus.i_req0 | bus.i_req1;
    // Contention goes to whoever was not granted last; a lone request always wins.
    w_win        = (bus.i_req0 & bus.i_req1) ? ~r_last : bus.i_req1;
    w_last_cycle = (r_cnt == 3'd1);
    w_next       = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = w_last_cycle ? S_DONE : S_EXEC;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_cnt     <= 3'd0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_result  <= 4'd0;
      r_carry   <= 1'b0;
      r_alu_sel <= 3'd0;
      r_alu_a   <= 4'd0;
      r_alu_b   <= 4'd0;
      r_alu_c   <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner   <= w_win;
            r_last    <= w_win;
            r_cnt     <= c_LAT;
            r_gnt0    <= ~w_win;
            r_gnt1    <= w_win;
            r_alu_sel <= w_win ? bus.i_op1 : bus.i_op0;
            r_alu_a   <= w_win ? bus.i_a1  : bus.i_a0;
            r_alu_b   <= w_win ? bus.i_b1  : bus.i_b0;
            r_alu_c   <= w_win ? bus.i_c1  : bus.i_c0;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - 3'd1;
          if (w_last_cycle) begin
            r_result <= bus.i_alu_out;
            r_carry  <= bus.i_alu_cout;
            r_done0  <= ~r_owner;
            r_done1  <= r_owner;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_gnt0       = r_gnt0;
  assign bus.o_gnt1       = r_gnt1;
  assign bus.o_done0      = r_done0;
  assign bus.o_done1      = r_done1;
  assign bus.o_result     = r_result;
  assign bus.o_carry      = r_carry;
  assign bus.o_busy       = (r_state == S_EXEC) || (r_state == S_DONE);
  assign bus.o_alu_select = r_alu_sel;
  assign bus.o_alu_a      = r_alu_a;
  assign bus.o_alu_b      = r_alu_b;
  assign bus.o_alu_c      = r_alu_c;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Directed bench for alu_arbiter with ALU_LAT=1 and ALU_LAT=3 instances.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  alu_arbiter_if u_if1 ();
  alu_arbiter_if u_if3 ();

  alu_arbiter #(.ALU_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  alu_arbiter #(.ALU_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if3));

  always #5 clk = ~clk;

  // Returns {carry_out, result}; rotate is left through C.
  function automatic logic [4:0] alu_f(input logic [2:0] sel, input logic [3:0] a,
                                       input logic [3:0] b, input logic c);
    logic [4:0] r;
    case (sel)
      3'b000:  r = {1'b0, ~a};
      3'b001:  r = {1'b0, a} + {1'b0, b} + {4'b0000, c};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {a[3], a[2:0], c};
      3'b110:  r = 5'b00000;
      default: r = 5'b01111;
    endcase
    return r;
  endfunction

  logic [4:0] w_f1;
  logic [4:0] w_f3;
  logic [4:0] r_p3a;
  logic [4:0] r_p3b;

  assign w_f1 = alu_f(u_if1.o_alu_select, u_if1.o_alu_a, u_if1.o_alu_b, u_if1.o_alu_c);
  assign u_if1.i_alu_out  = w_f1[3:0];
  assign u_if1.i_alu_cout = w_f1[4];

  assign w_f3 = alu_f(u_if3.o_alu_select, u_if3.o_alu_a, u_if3.o_alu_b, u_if3.o_alu_c);
  always @(posedge clk) begin
    r_p3a <= w_f3;
    r_p3b <= r_p3a;
  end
  assign u_if3.i_alu_out  = r_p3b[3:0];
  assign u_if3.i_alu_cout = r_p3b[4];

  // {gnt0, gnt1, done0, done1, busy}
  logic [4:0]  w_st1;
  logic [4:0]  w_st3;
  logic [11:0] w_alu1;
  assign w_st1  = {u_if1.o_gnt0, u_if1.o_gnt1, u_if1.o_done0, u_if1.o_done1, u_if1.o_busy};
  assign w_st3  = {u_if3.o_gnt0, u_if3.o_gnt1, u_if3.o_done0, u_if3.o_done1, u_if3.o_busy};
  assign w_alu1 = {u_if1.o_alu_select, u_if1.o_alu_a, u_if1.o_alu_b, u_if1.o_alu_c};

  localparam logic [2:0] c_ops   [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b101};
  localparam logic       c_cin   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [3:0] c_res   [5] = '{4'b0101, 4'b1111, 4'b0000, 4'b1100, 4'b0100};
  localparam logic       c_cout  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if ({w_st1, u_if1.o_result, u_if1.o_carry} !== 10'b0)
      $display("FAIL reset_outputs1: got %b want %b", {w_st1, u_if1.o_result, u_if1.o_carry}, 10'b0);
    total++;
    if (w_alu1 !== 12'b0)
      $display("FAIL reset_alu_bus1: got %b want %b", w_alu1, 12'b0);
    total++;
    if ({w_st3, u_if3.o_result, u_if3.o_carry} !== 10'b0)
      $display("FAIL reset_outputs3: got %b want %b", {w_st3, u_if3.o_result, u_if3.o_carry}, 10'b0);
    if ({w_st1, u_if1.o_result, u_if1.o_carry} !== 10'b0) bad++;
    if (w_alu1 !== 12'b0) bad++;
    if ({w_st3, u_if3.o_result, u_if3.o_carry} !== 10'b0) bad++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    @(negedge clk);
    u_if1.i_req0 = 1'b1; u_if1.i_op0 = 3'b001;
    u_if1.i_a0 = 4'b1010; u_if1.i_b0 = 4'b0101; u_if1.i_c0 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b10001) begin bad++; $display("FAIL add_grant: got %b want %b", w_st1, 5'b10001); end
    total++;
    if (w_alu1 !== 12'b001_1010_0101_1) begin
      bad++; $display("FAIL add_alu_bus: got %b want %b", w_alu1, 12'b001_1010_0101_1);
    end
    u_if1.i_req0 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b00101) begin bad++; $display("FAIL add_done: got %b want %b", w_st1, 5'b00101); end
    total++;
    if ({u_if1.o_result, u_if1.o_carry} !== 5'b0000_1) begin
      bad++; $display("FAIL add_result: got %b want %b", {u_if1.o_result, u_if1.o_carry}, 5'b0000_1);
    end
    @(posedge clk); #1;
    total++;
    if ({w_st1, u_if1.o_result, u_if1.o_carry} !== 10'b00000_0000_1) begin
      bad++; $display("FAIL add_idle_hold: got %b want %b", {w_st1, u_if1.o_result, u_if1.o_carry}, 10'b00000_0000_1);
    end
  endtask

  task automatic test_ops;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      u_if1.i_req0 = 1'b1; u_if1.i_op0 = c_ops[i];
      u_if1.i_a0 = 4'b1010; u_if1.i_b0 = 4'b0110; u_if1.i_c0 = c_cin[i];
      @(posedge clk); #1;
      total++;
      if ({u_if1.o_gnt0, u_if1.o_alu_select, u_if1.o_alu_c} !== {1'b1, c_ops[i], c_cin[i]}) begin
        bad++;
        $display("FAIL ops_grant[%0d]: got %b want %b", i,
                 {u_if1.o_gnt0, u_if1.o_alu_select, u_if1.o_alu_c}, {1'b1, c_ops[i], c_cin[i]});
      end
      u_if1.i_req0 = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({u_if1.o_done0, u_if1.o_result, u_if1.o_carry} !== {1'b1, c_res[i], c_cout[i]}) begin
        bad++;
        $display("FAIL ops_result[%0d]: got %b want %b", i,
                 {u_if1.o_done0, u_if1.o_result, u_if1.o_carry}, {1'b1, c_res[i], c_cout[i]});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alternate;
    logic [4:0] v_exp;
    rst_n = 1'b0;
    u_if1.i_op0 = 3'b010; u_if1.i_a0 = 4'b1100; u_if1.i_b0 = 4'b1010; u_if1.i_c0 = 1'b0;
    u_if1.i_op1 = 3'b011; u_if1.i_a1 = 4'b1100; u_if1.i_b1 = 4'b0011; u_if1.i_c1 = 1'b0;
    u_if1.i_req0 = 1'b1; u_if1.i_req1 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      v_exp = {(t == 1 || t == 7), (t == 4 || t == 10), (t == 2 || t == 8),
               (t == 5 || t == 11), (t % 3 != 0)};
      total++;
      if (w_st1 !== v_exp) begin
        bad++; $display("FAIL alternate_t%0d: got %b want %b", t, w_st1, v_exp);
      end
      if (v_exp[2]) begin
        total++;
        if ({u_if1.o_result, u_if1.o_carry} !== 5'b1000_0) begin
          bad++; $display("FAIL alternate_res0_t%0d: got %b want %b", t, {u_if1.o_result, u_if1.o_carry}, 5'b1000_0);
        end
      end
      if (v_exp[1]) begin
        total++;
        if ({u_if1.o_result, u_if1.o_carry} !== 5'b1111_0) begin
          bad++; $display("FAIL alternate_res1_t%0d: got %b want %b", t, {u_if1.o_result, u_if1.o_carry}, 5'b1111_0);
        end
      end
      if (t == 12) u_if1.i_req0 = 1'b0;
    end
  endtask

  // Continues from test_alternate: req1 alone, pointer last pointing at 1.
  task automatic test_lone_req1;
    logic [4:0] v_exp;
    for (int t = 1; t <= 9; t++) begin
      @(posedge clk); #1;
      v_exp = {1'b0, (t % 3 == 1), 1'b0, (t % 3 == 2), (t % 3 != 0)};
      total++;
      if (w_st1 !== v_exp) begin
        bad++; $display("FAIL lone_req1_t%0d: got %b want %b", t, w_st1, v_exp);
      end
      if (t == 9) u_if1.i_req1 = 1'b0;
    end
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b00000) begin bad++; $display("FAIL lone_release: got %b want %b", w_st1, 5'b00000); end
  endtask

  task automatic test_drop_and_ignore;
    @(negedge clk);
    u_if1.i_req0 = 1'b1;
    #2 u_if1.i_req0 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b00000) begin bad++; $display("FAIL dropped_req: got %b want %b", w_st1, 5'b00000); end
    @(negedge clk);
    u_if1.i_req0 = 1'b1; u_if1.i_op0 = 3'b011; u_if1.i_a0 = 4'b0001; u_if1.i_b0 = 4'b0010; u_if1.i_c0 = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk); #1;
      case (t)
        1: begin
          total++;
          if (w_st1 !== 5'b10001) begin bad++; $display("FAIL ignore_gnt0: got %b want %b", w_st1, 5'b10001); end
          u_if1.i_req0 = 1'b0; u_if1.i_a0 = 4'b1111;
          u_if1.i_req1 = 1'b1; u_if1.i_op1 = 3'b000; u_if1.i_a1 = 4'b0000; u_if1.i_b1 = 4'b0000; u_if1.i_c1 = 1'b0;
        end
        2: begin
          total++;
          if ({w_st1, u_if1.o_alu_a, u_if1.o_result} !== {5'b00101, 4'b0001, 4'b0011}) begin
            bad++;
            $display("FAIL ignore_done0: got %b want %b", {w_st1, u_if1.o_alu_a, u_if1.o_result},
                     {5'b00101, 4'b0001, 4'b0011});
          end
        end
        3: begin
          total++;
          if (w_st1 !== 5'b00000) begin bad++; $display("FAIL ignore_idle: got %b want %b", w_st1, 5'b00000); end
        end
        4: begin
          total++;
          if (w_st1 !== 5'b01001) begin bad++; $display("FAIL ignore_gnt1: got %b want %b", w_st1, 5'b01001); end
          u_if1.i_req1 = 1'b0;
        end
        5: begin
          total++;
          if ({w_st1, u_if1.o_result} !== {5'b00011, 4'b1111}) begin
            bad++; $display("FAIL ignore_done1: got %b want %b", {w_st1, u_if1.o_result}, {5'b00011, 4'b1111});
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_exec;
    @(negedge clk);
    u_if1.i_req0 = 1'b1; u_if1.i_op0 = 3'b111;
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b10001) begin bad++; $display("FAIL midrst_gnt: got %b want %b", w_st1, 5'b10001); end
    u_if1.i_req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({w_st1, u_if1.o_result, u_if1.o_carry, w_alu1} !== 22'b0) begin
      bad++; $display("FAIL midrst_clear: got %b want %b", {w_st1, u_if1.o_result, u_if1.o_carry, w_alu1}, 22'b0);
    end
    u_if1.i_op0 = 3'b001; u_if1.i_a0 = 4'b0011; u_if1.i_b0 = 4'b0001; u_if1.i_c0 = 1'b0;
    u_if1.i_req0 = 1'b1; u_if1.i_req1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b00000) begin bad++; $display("FAIL midrst_no_done: got %b want %b", w_st1, 5'b00000); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (w_st1 !== 5'b10001) begin bad++; $display("FAIL midrst_first_gnt0: got %b want %b", w_st1, 5'b10001); end
    u_if1.i_req0 = 1'b0; u_if1.i_req1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({w_st1, u_if1.o_result} !== {5'b00101, 4'b0100}) begin
      bad++; $display("FAIL midrst_result: got %b want %b", {w_st1, u_if1.o_result}, {5'b00101, 4'b0100});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lat3;
    logic [4:0] v_exp;
    @(negedge clk);
    u_if3.i_req0 = 1'b1; u_if3.i_op0 = 3'b001;
    u_if3.i_a0 = 4'b0011; u_if3.i_b0 = 4'b0100; u_if3.i_c0 = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk); #1;
      v_exp = {(t == 1), 1'b0, (t == 4), 1'b0, (t <= 4)};
      total++;
      if ({w_st3, u_if3.o_alu_select, u_if3.o_alu_a} !== {v_exp, 3'b001, 4'b0011}) begin
        bad++;
        $display("FAIL lat3_t%0d: got %b want %b", t, {w_st3, u_if3.o_alu_select, u_if3.o_alu_a},
                 {v_exp, 3'b001, 4'b0011});
      end
      if (t == 1) u_if3.i_req0 = 1'b0;
      if (t == 4) begin
        total++;
        if ({u_if3.o_result, u_if3.o_carry} !== 5'b0111_0) begin
          bad++; $display("FAIL lat3_result: got %b want %b", {u_if3.o_result, u_if3.o_carry}, 5'b0111_0);
        end
      end
    end
  endtask

  initial begin
    u_if1.i_req0 = 1'b0; u_if1.i_req1 = 1'b0;
    u_if1.i_op0 = 3'b000; u_if1.i_op1 = 3'b000;
    u_if1.i_a0 = 4'b0000; u_if1.i_b0 = 4'b0000; u_if1.i_a1 = 4'b0000; u_if1.i_b1 = 4'b0000;
    u_if1.i_c0 = 1'b0; u_if1.i_c1 = 1'b0;
    u_if3.i_req0 = 1'b0; u_if3.i_req1 = 1'b0;
    u_if3.i_op0 = 3'b000; u_if3.i_op1 = 3'b000;
    u_if3.i_a0 = 4'b0000; u_if3.i_b0 = 4'b0000; u_if3.i_a1 = 4'b0000; u_if3.i_b1 = 4'b0000;
    u_if3.i_c0 = 1'b0; u_if3.i_c1 = 1'b0;
    test_reset();
    test_add();
    test_ops();
    test_alternate();
    test_lone_req1();
    test_drop_and_ignore();
    test_reset_mid_exec();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, legal range 1..7; cycles from ALU operand drive to a valid ALU registered result.
REQ-002 clock  in  1  single system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req0 / req1  in  1 each  operation request from requester 0 / 1, level-held until granted.
REQ-005 op0 / op1  in  3 each  ALU select code: 000 NOT A, 001 A+B+C, 010 A AND B, 011 A OR B, 100 A XOR B, 101 rotate A through C, 110 zero, 111 ones.
REQ-006 a0, b0 / a1, b1  in  4 each  operands; c0 / c1  in  1 each  carry/rotate input.
REQ-007 gnt0 / gnt1  out  1 each  one-cycle pulse, request accepted and operands captured.
REQ-008 done0 / done1  out  1 each  one-cycle pulse, result for that requester valid.
REQ-009 result  out  4  and  carry  out  1  shared result bus, valid while a done pulse is high, then held.
REQ-010 busy  out  1  high while an operation is in flight.
REQ-011 alu_select  out  3, alu_a  out  4, alu_b  out  4, alu_c  out  1  registered drive to the shared ALU.
REQ-012 alu_out  in  4  and  alu_cout  in  1  ALU registered result and carry-out.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, DONE; any unreachable encoding SHALL go to IDLE on the next edge.
REQ-014 IDLE: on an edge where req0 or req1 is high, the block SHALL pick a winner, capture that requester's op/a/b/c into alu_select/alu_a/alu_b/alu_c, pulse its gnt in the following cycle, load the wait counter with ALU_LAT, and enter EXEC.
REQ-015 Arbitration SHALL be round-robin: a last-grant pointer, reset value 1, so requester 0 wins the first simultaneous request. On simultaneous requests, the requester not granted last SHALL win. A lone requester SHALL win regardless of the pointer.
REQ-016 EXEC: alu_* SHALL stay stable and the counter SHALL decrement each cycle. On the edge where the counter equals 1, the block SHALL capture alu_out into result and alu_cout into carry, and enter DONE.
REQ-017 DONE: the owner's done SHALL be high for exactly this cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: request sampled at edge k gives gnt high in cycle k+1 and done high in cycle k+1+ALU_LAT. Back-to-back throughput is one operation per ALU_LAT+2 cycles.
REQ-019 Requests arriving or changing during EXEC/DONE SHALL be ignored until IDLE. A request dropped before its sampling edge SHALL produce no operation. A request still high in IDLE after done SHALL be treated as a new operation.
REQ-020 Operands SHALL pass through unmodified; alu_c SHALL carry the requester's c for every op code.
REQ-021 In IDLE, alu_*, result and carry SHALL hold their last values. busy SHALL be high in EXEC and DONE only.
REQ-022 At most one gnt and at most one done SHALL be high in any cycle.

Reset
REQ-023 reset low SHALL immediately force IDLE, gnt0=gnt1=0, done0=done1=0, result=0000, carry=0, busy=0, alu_select=000, alu_a=alu_b=0000, alu_c=0, last-grant pointer=1, counter=0.
REQ-024 reset asserted during EXEC or DONE SHALL discard the in-flight operation with no done pulse.
REQ-025 After reset deasserts, the first rising edge SHALL perform normal IDLE arbitration.

Verification (behavioural ALU model, ALU_LAT=1 unless stated)
REQ-026 Scenario: req0 with op=001, a=1010, b=0101, c=1 at edge k -> gnt0 in cycle k+1, done0 in cycle k+2, result=0000, carry=1.
REQ-027 Scenario: req0 and req1 both held from reset release -> grants alternate gnt0, gnt1, gnt0, gnt1, spaced 3 cycles apart.
REQ-028 Scenario: req1 alone, held continuously -> gnt1 every 3 cycles with no starvation; no gnt0 ever.
REQ-029 Scenario: reset low mid-EXEC -> all outputs zero within the same cycle, no done. Then req0 and req1 simultaneously -> gnt0 first.
REQ-030 Scenario: op=000 with a=1010 -> result 0101. op=111 -> result 1111. op=110 -> result 0000.
REQ-031 Scenario: ALU_LAT=3 with a single req0 at edge k -> done0 in cycle k+4, busy high in cycles k+1 through k+4.
